// File: rtl/bpf_pkg.sv
// Shared types and constants for the BPF filter-core control blocks.
//   state_t        : PC controller sequencing states
//   INSN_CNT_WIDTH : width of the per-packet fetched-instruction counter
//   RESULT_WIDTH   : width of the accept length handed to the forwarder
package bpf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FLUSH  = 2'd2,
        REPORT = 2'd3
    } state_t;

    localparam int INSN_CNT_WIDTH = 16;
    localparam int RESULT_WIDTH   = 32;

endpackage

// File: rtl/bpf_pc_ctrl.sv
// Program-counter and run-sequencing controller for the pipelined BPF core.
// Takes ownership of a ready packet, drives the instruction address, applies
// fetch-advance and mispredict redirects, and on RET or watchdog expiry
// flushes the pipeline and presents the accept length to the forwarder.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a packet; PC parked at 0, ack is combinational
// RUN    | core enabled; PC follows advance/redirect, watchdog counting
// FLUSH  | one-cycle pipeline clear after RET or watchdog hit
// REPORT | result_vld held with stable data until result_rdy
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   pkt_vld / pkt_ack             packet handoff from the packet buffer
//   PC_en                         fetch advance strobe
//   branch_mispredict/_target     execute-stage redirect
//   ret_vld / ret_val             RET retired with accept length
//   inst_addr                     current PC to instruction memory
//   running                       core enable
//   flush                         one-cycle pipeline clear
//   result_vld/_len/_timeout/_rdy result handshake to the forwarder
module bpf_pc_ctrl
    import bpf_pkg::*;
#(
    parameter int CODE_ADDR_WIDTH = 10,
    parameter int MAX_INSNS       = 1023
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pkt_vld,
    output logic                       pkt_ack,
    input  logic                       PC_en,
    input  logic                       branch_mispredict,
    input  logic [CODE_ADDR_WIDTH-1:0] branch_target,
    input  logic                       ret_vld,
    input  logic [RESULT_WIDTH-1:0]    ret_val,
    output logic [CODE_ADDR_WIDTH-1:0] inst_addr,
    output logic                       running,
    output logic                       flush,
    output logic                       result_vld,
    output logic [RESULT_WIDTH-1:0]    result_len,
    output logic                       result_timeout,
    input  logic                       result_rdy
);

    state_t                      state, state_nxt;
    logic [CODE_ADDR_WIDTH-1:0]  pc;
    logic [INSN_CNT_WIDTH-1:0]   insn_cnt;
    logic [RESULT_WIDTH-1:0]     res_len;
    logic                        res_timeout;
    logic                        ret_take;
    logic                        wd_hit;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        pkt_ack    = 1'b0;
        running    = 1'b0;
        flush      = 1'b0;
        result_vld = 1'b0;
        ret_take   = 1'b0;
        wd_hit     = 1'b0;
        case (state)
            IDLE: begin
                if (pkt_vld) begin
                    pkt_ack   = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                running  = 1'b1;
                ret_take = ret_vld;
                // RET wins over a watchdog hit in the same cycle
                wd_hit   = !ret_vld && (insn_cnt == INSN_CNT_WIDTH'(MAX_INSNS));
                if (ret_take || wd_hit) state_nxt = FLUSH;
            end
            FLUSH: begin
                flush     = 1'b1;
                state_nxt = REPORT;
            end
            REPORT: begin
                result_vld = 1'b1;
                if (result_rdy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // a packet seen during reset must not be acked; reset discards it
        if (rst) pkt_ack = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= '0;
            insn_cnt    <= '0;
            res_len     <= '0;
            res_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pc <= '0;
                    if (pkt_vld) insn_cnt <= '0;
                end
                RUN: begin
                    if (ret_take) begin
                        pc          <= '0;
                        res_len     <= ret_val;
                        res_timeout <= 1'b0;
                    end else if (wd_hit) begin
                        pc          <= '0;
                        res_len     <= '0;
                        res_timeout <= 1'b1;
                    end else begin
                        if (branch_mispredict) pc <= branch_target;
                        else if (PC_en)        pc <= pc + CODE_ADDR_WIDTH'(1);
                        // redirected fetches are not counted against the watchdog
                        if (PC_en && !branch_mispredict)
                            insn_cnt <= insn_cnt + INSN_CNT_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign inst_addr      = pc;
    assign result_len     = res_len;
    assign result_timeout = res_timeout;

endmodule

// File: tb/tb_bpf_pc_ctrl.sv
module tb_bpf_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        pkt_vld;
    logic        PC_en;
    logic        branch_mispredict;
    logic [9:0]  branch_target;
    logic        ret_vld;
    logic [31:0] ret_val;
    logic        result_rdy;

    logic        a_pkt_ack, a_running, a_flush, a_result_vld, a_result_timeout;
    logic [9:0]  a_inst_addr;
    logic [31:0] a_result_len;

    logic        b_pkt_ack, b_running, b_flush, b_result_vld, b_result_timeout;
    logic [3:0]  b_inst_addr;
    logic [31:0] b_result_len;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bpf_pc_ctrl #(.CODE_ADDR_WIDTH(10), .MAX_INSNS(8)) dut_a (
        .clk(clk), .rst(rst), .pkt_vld(pkt_vld), .pkt_ack(a_pkt_ack),
        .PC_en(PC_en), .branch_mispredict(branch_mispredict),
        .branch_target(branch_target), .ret_vld(ret_vld), .ret_val(ret_val),
        .inst_addr(a_inst_addr), .running(a_running), .flush(a_flush),
        .result_vld(a_result_vld), .result_len(a_result_len),
        .result_timeout(a_result_timeout), .result_rdy(result_rdy)
    );

    bpf_pc_ctrl #(.CODE_ADDR_WIDTH(4), .MAX_INSNS(1023)) dut_b (
        .clk(clk), .rst(rst), .pkt_vld(pkt_vld), .pkt_ack(b_pkt_ack),
        .PC_en(PC_en), .branch_mispredict(branch_mispredict),
        .branch_target(branch_target[3:0]), .ret_vld(ret_vld), .ret_val(ret_val),
        .inst_addr(b_inst_addr), .running(b_running), .flush(b_flush),
        .result_vld(b_result_vld), .result_len(b_result_len),
        .result_timeout(b_result_timeout), .result_rdy(result_rdy)
    );

    // inputs change and outputs are sampled 1ns after each rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; pkt_vld = 0; PC_en = 0; branch_mispredict = 0;
        branch_target = '0; ret_vld = 0; ret_val = '0; result_rdy = 0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic start_pkt();
        pkt_vld = 1'b1;
        step();
        pkt_vld = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (a_inst_addr !== 10'd0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", a_inst_addr); end
        checks++; if (a_running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", a_running); end
        checks++; if (a_flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", a_flush); end
        checks++; if (a_pkt_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", a_pkt_ack); end
        checks++; if (a_result_vld !== 1'b0) begin failures++; $display("FAIL reset_rvld got=%b exp=0", a_result_vld); end
        checks++; if (a_result_len !== 32'd0) begin failures++; $display("FAIL reset_len got=%0h exp=0", a_result_len); end
        checks++; if (a_result_timeout !== 1'b0) begin failures++; $display("FAIL reset_to got=%b exp=0", a_result_timeout); end
        checks++; if (dut_a.insn_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", dut_a.insn_cnt); end
    endtask

    task automatic test_basic();
        do_reset();
        pkt_vld = 1'b1;
        #1;
        checks++; if (a_pkt_ack !== 1'b1) begin failures++; $display("FAIL basic_ack got=%b exp=1", a_pkt_ack); end
        step();
        pkt_vld = 1'b0;
        #1;
        checks++; if (a_pkt_ack !== 1'b0) begin failures++; $display("FAIL basic_ack_pulse got=%b exp=0", a_pkt_ack); end
        checks++; if (a_running !== 1'b1) begin failures++; $display("FAIL basic_running got=%b exp=1", a_running); end
        checks++; if (a_inst_addr !== 10'd0) begin failures++; $display("FAIL basic_addr0 got=%0h exp=0", a_inst_addr); end
        PC_en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            checks++; if (a_inst_addr !== 10'(i)) begin failures++; $display("FAIL basic_adv got=%0h exp=%0h", a_inst_addr, i); end
        end
        PC_en = 1'b0;
        ret_vld = 1'b1; ret_val = 32'd64;
        step();
        ret_vld = 1'b0; ret_val = '0;
        checks++; if (a_flush !== 1'b1) begin failures++; $display("FAIL basic_flush got=%b exp=1", a_flush); end
        checks++; if (a_running !== 1'b0) begin failures++; $display("FAIL basic_flush_run got=%b exp=0", a_running); end
        checks++; if (a_result_vld !== 1'b0) begin failures++; $display("FAIL basic_early_rvld got=%b exp=0", a_result_vld); end
        step();
        checks++; if (a_flush !== 1'b0) begin failures++; $display("FAIL basic_flush_once got=%b exp=0", a_flush); end
        checks++; if (a_result_vld !== 1'b1) begin failures++; $display("FAIL basic_rvld got=%b exp=1", a_result_vld); end
        checks++; if (a_result_len !== 32'd64) begin failures++; $display("FAIL basic_len got=%0d exp=64", a_result_len); end
        checks++; if (a_result_timeout !== 1'b0) begin failures++; $display("FAIL basic_to got=%b exp=0", a_result_timeout); end
        result_rdy = 1'b1;
        step();
        result_rdy = 1'b0;
        checks++; if (a_result_vld !== 1'b0) begin failures++; $display("FAIL basic_rvld_drop got=%b exp=0", a_result_vld); end
    endtask

    task automatic test_redirect();
        do_reset();
        start_pkt();
        PC_en = 1'b1;
        repeat (3) step();
        checks++; if (a_inst_addr !== 10'd3) begin failures++; $display("FAIL redir_pre got=%0h exp=3", a_inst_addr); end
        branch_mispredict = 1'b1; branch_target = 10'h20;
        step();
        branch_mispredict = 1'b0; PC_en = 1'b0;
        checks++; if (a_inst_addr !== 10'h20) begin failures++; $display("FAIL redir_addr got=%0h exp=20", a_inst_addr); end
        checks++; if (dut_a.insn_cnt !== 16'd3) begin failures++; $display("FAIL redir_cnt got=%0d exp=3", dut_a.insn_cnt); end
    endtask

    task automatic test_ret_and_mispredict();
        do_reset();
        start_pkt();
        PC_en = 1'b1;
        repeat (2) step();
        PC_en = 1'b0;
        ret_vld = 1'b1; ret_val = 32'h1234; branch_mispredict = 1'b1; branch_target = 10'd7;
        step();
        ret_vld = 1'b0; branch_mispredict = 1'b0;
        checks++; if (a_inst_addr !== 10'd0) begin failures++; $display("FAIL retmis_addr got=%0h exp=0", a_inst_addr); end
        checks++; if (a_flush !== 1'b1) begin failures++; $display("FAIL retmis_flush got=%b exp=1", a_flush); end
        step();
        checks++; if (a_result_len !== 32'h1234) begin failures++; $display("FAIL retmis_len got=%0h exp=1234", a_result_len); end
        checks++; if (a_result_timeout !== 1'b0) begin failures++; $display("FAIL retmis_to got=%b exp=0", a_result_timeout); end
    endtask

    task automatic test_watchdog_backpressure();
        logic [31:0] held_len;
        do_reset();
        start_pkt();
        PC_en = 1'b1;
        repeat (8) step();
        checks++; if (a_inst_addr !== 10'd8) begin failures++; $display("FAIL wd_addr8 got=%0h exp=8", a_inst_addr); end
        checks++; if (a_running !== 1'b1) begin failures++; $display("FAIL wd_still_run got=%b exp=1", a_running); end
        step();
        checks++; if (a_flush !== 1'b1) begin failures++; $display("FAIL wd_flush got=%b exp=1", a_flush); end
        checks++; if (a_inst_addr !== 10'd0) begin failures++; $display("FAIL wd_addr0 got=%0h exp=0", a_inst_addr); end
        PC_en = 1'b0;
        step();
        checks++; if (a_result_vld !== 1'b1) begin failures++; $display("FAIL wd_rvld got=%b exp=1", a_result_vld); end
        checks++; if (a_result_len !== 32'd0) begin failures++; $display("FAIL wd_len got=%0h exp=0", a_result_len); end
        checks++; if (a_result_timeout !== 1'b1) begin failures++; $display("FAIL wd_to got=%b exp=1", a_result_timeout); end
        held_len = 32'd0;
        pkt_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (a_pkt_ack !== 1'b0) begin failures++; $display("FAIL bp_ack got=%b exp=0 cyc=%0d", a_pkt_ack, i); end
            checks++; if (a_result_vld !== 1'b1 || a_result_len !== held_len || a_result_timeout !== 1'b1)
                begin failures++; $display("FAIL bp_hold vld=%b len=%0h to=%b exp vld=1 len=%0h to=1", a_result_vld, a_result_len, a_result_timeout, held_len); end
            step();
        end
        pkt_vld = 1'b0; result_rdy = 1'b1;
        step();
        result_rdy = 1'b0;
        checks++; if (a_result_vld !== 1'b0) begin failures++; $display("FAIL bp_release got=%b exp=0", a_result_vld); end
        checks++; if (a_running !== 1'b0) begin failures++; $display("FAIL bp_idle_run got=%b exp=0", a_running); end
        pkt_vld = 1'b1;
        #1;
        checks++; if (a_pkt_ack !== 1'b1) begin failures++; $display("FAIL bp_idle_ack got=%b exp=1", a_pkt_ack); end
        pkt_vld = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        start_pkt();
        branch_mispredict = 1'b1; branch_target = 10'd15;
        step();
        branch_mispredict = 1'b0;
        checks++; if (b_inst_addr !== 4'd15) begin failures++; $display("FAIL wrap_pre got=%0h exp=f", b_inst_addr); end
        PC_en = 1'b1;
        step();
        PC_en = 1'b0;
        checks++; if (b_inst_addr !== 4'd0) begin failures++; $display("FAIL wrap_addr got=%0h exp=0", b_inst_addr); end
        checks++; if (a_inst_addr !== 10'd16) begin failures++; $display("FAIL wrap_wide got=%0h exp=10", a_inst_addr); end
        checks++; if (b_running !== 1'b1) begin failures++; $display("FAIL wrap_run got=%b exp=1", b_running); end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        start_pkt();
        branch_mispredict = 1'b1; branch_target = 10'd9;
        step();
        branch_mispredict = 1'b0;
        checks++; if (a_inst_addr !== 10'd9) begin failures++; $display("FAIL rmr_pre got=%0h exp=9", a_inst_addr); end
        rst = 1'b1;
        pkt_vld = 1'b1;
        #1;
        checks++; if (a_pkt_ack !== 1'b0) begin failures++; $display("FAIL rmr_ack_in_rst got=%b exp=0", a_pkt_ack); end
        step();
        rst = 1'b0; pkt_vld = 1'b0;
        checks++; if (a_inst_addr !== 10'd0) begin failures++; $display("FAIL rmr_addr got=%0h exp=0", a_inst_addr); end
        checks++; if (a_running !== 1'b0) begin failures++; $display("FAIL rmr_run got=%b exp=0", a_running); end
        checks++; if (a_result_vld !== 1'b0 || a_flush !== 1'b0) begin failures++; $display("FAIL rmr_out rvld=%b flush=%b exp 0 0", a_result_vld, a_flush); end
        step();
        checks++; if (a_result_vld !== 1'b0) begin failures++; $display("FAIL rmr_no_result got=%b exp=0", a_result_vld); end
        pkt_vld = 1'b1;
        #1;
        checks++; if (a_pkt_ack !== 1'b1) begin failures++; $display("FAIL rmr_new_ack got=%b exp=1", a_pkt_ack); end
        step();
        pkt_vld = 1'b0;
        checks++; if (a_running !== 1'b1 || a_inst_addr !== 10'd0) begin failures++; $display("FAIL rmr_new_run run=%b addr=%0h exp 1 0", a_running, a_inst_addr); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int p = 0; p < 2; p++) begin
            start_pkt();
            ret_vld = 1'b1; ret_val = 32'(100 + p);
            step();
            ret_vld = 1'b0;
            step();
            result_rdy = 1'b1;
            checks++; if (a_result_vld !== 1'b1 || a_result_len !== 32'(100 + p))
                begin failures++; $display("FAIL b2b_result vld=%b len=%0d exp vld=1 len=%0d", a_result_vld, a_result_len, 100 + p); end
            step();
            result_rdy = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_redirect();
        test_ret_and_mispredict();
        test_watchdog_backpressure();
        test_wrap();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bpf_pc_ctrl.md
# bpf_pc_ctrl

Program-counter and run-sequencing controller for the pipelined BPF filter core. It sits between the packet buffer, the instruction memory and the fetch/execute stages. It takes ownership of a ready packet, drives the instruction address, and applies fetch-advance and mispredict redirects. On RET or watchdog expiry it flushes the pipeline and hands the accept length to the forwarder.

## Interface
Parameters:
- CODE_ADDR_WIDTH, 10, instruction memory address width; PC wraps modulo 2^CODE_ADDR_WIDTH
- MAX_INSNS, 1023, watchdog limit on fetched instructions per packet (1..2^16-1)

Ports:
- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- pkt_vld  in  1  packet buffer holds a packet awaiting filtering
- pkt_ack  out  1  one-cycle pulse: controller has taken the packet
- PC_en  in  1  fetch stage advance/redirect strobe
- branch_mispredict  in  1  execute stage redirect request
- branch_target  in  CODE_ADDR_WIDTH  redirect address, valid with branch_mispredict
- ret_vld  in  1  RET retired this cycle
- ret_val  in  32  accept length carried by RET (0 = reject)
- inst_addr  out  CODE_ADDR_WIDTH  current PC to instruction memory
- running  out  1  core enable; fetch stage ANDs this into its next_rdy
- flush  out  1  one-cycle pipeline clear
- result_vld  out  1  result available
- result_len  out  32  accept length
- result_timeout  out  1  result was forced by watchdog
- result_rdy  in  1  forwarder accepts result

## Operation
- FSM states: IDLE, RUN, FLUSH, REPORT. Encoding is in the package.
- IDLE:
  - PC = 0, running = 0.
  - pkt_ack = pkt_vld (combinational, IDLE only).
  - pkt_vld → RUN next cycle; insn counter cleared.
- RUN: running = 1. PC update priority, highest first:
  - ret_vld or watchdog hit → PC <= 0, go FLUSH.
  - branch_mispredict → PC <= branch_target.
  - PC_en → PC <= PC+1, wrapping max → 0.
  - Otherwise PC holds.
- Insn counter (16 bit) increments on PC_en && !branch_mispredict in RUN.
- Watchdog hit: counter == MAX_INSNS while in RUN and ret_vld low. Latches result_len = 0 and timeout = 1.
- ret_vld latches result_len = ret_val and timeout = 0. ret_vld takes precedence over a watchdog hit in the same cycle.
- FLUSH: flush = 1 and running = 0 for exactly one cycle; always → REPORT.
- REPORT: result_vld = 1, with result_len and result_timeout held stable. result_rdy → IDLE next cycle.
- ret_vld, branch_mispredict and PC_en are ignored outside RUN.
- rst in any state → IDLE next cycle, packet not acked again, result discarded.

## Timing
- Reset values:
  - Outputs: inst_addr 0, running 0, flush 0, pkt_ack 0 (absent pkt_vld), result_vld 0, result_len 0, result_timeout 0.
  - Internal: insn counter 0.
- pkt_ack cycle N → running = 1 at N+1 with inst_addr = 0.
- PC update latency 1: redirect at N → inst_addr = branch_target at N+1.
- ret_vld at N → flush at N+1, result_vld at N+2.
- Minimum packet-to-packet spacing: 4 cycles (ack, RET, flush, report+rdy).
- result_vld follows valid/ready: once high it stays high, data stable, until the cycle result_rdy is sampled high. result_vld is low the following cycle.
- pkt_vld high while not IDLE: no ack and no effect.

## Structure
- Package bpf_pkg holds:
  - state enum {IDLE, RUN, FLUSH, REPORT}
  - INSN_CNT_WIDTH = 16
  - RESULT_WIDTH = 32
- Single module, no sub-modules. The watchdog counter is inline; it is too small to split out.

## Test plan
- Basic run: pkt_vld=1 → pkt_ack pulse, running=1. Five PC_en cycles → inst_addr 0,1,2,3,4,5. ret_vld with ret_val=64 → flush next cycle, then result_vld=1, result_len=64, result_timeout=0.
- Redirect: in RUN at PC=3, PC_en=1 and branch_mispredict=1 with target=0x20 → inst_addr=0x20 next cycle. Insn counter not incremented.
- Simultaneous RET and mispredict: ret_vld=1 and branch_mispredict=1 (target 7) → PC=0, FLUSH, result_len=ret_val. No jump taken.
- Watchdog: MAX_INSNS=8, PC_en held high, no RET → after 8 advances result_vld=1, result_len=0, result_timeout=1.
- Backpressure and wrap:
  - result_rdy low 5 cycles → result_vld and data stable; pkt_vld ignored, no ack. IDLE after rdy.
  - Separately, CODE_ADDR_WIDTH=4 at PC=15 with PC_en → PC=0.
- Reset mid-run: rst during RUN at PC=9 → next cycle IDLE, inst_addr=0, running=0, no result_vld. A new pkt_vld is acked normally.
